// File: rtl/y_operand_sel.sv
// Registered Y-operand selector with a req/ack fetch path for the I/O bus source.
// Define YSEL_TIMEOUT_EN to build the bus wait counter and timeout_err.
module y_operand_sel #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 8,
  parameter int SELW    = 3,
  parameter int BUS_SRC = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NSRC*WIDTH-1:0]   src_flat,
  input  logic [SELW-1:0]         sel,
  input  logic                    req,
  output logic                    bus_req,
  input  logic                    bus_ack,
  output logic [WIDTH-1:0]        y_out,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic {
    S_IDLE,
    S_BUSWAIT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_terr;

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_bus_data;
  logic             w_in_range;
  logic             w_is_bus;
  logic             w_expire;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) w_sel_data = src_flat[i*WIDTH +: WIDTH];
    end
  end

  assign w_bus_data = src_flat[BUS_SRC*WIDTH +: WIDTH];
  assign w_in_range = {1'b0, sel} < (SELW+1)'(NSRC);
  assign w_is_bus   = sel == SELW'(BUS_SRC);

`ifdef YSEL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] r_cnt;

  assign w_expire = (r_state == S_BUSWAIT) &&
                    (r_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_terr  <= 1'b0;
`ifdef YSEL_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_terr  <= 1'b0;
`ifdef YSEL_TIMEOUT_EN
      r_cnt   <= (r_state == S_BUSWAIT) ? r_cnt + 1'b1 : '0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            if (!w_in_range) begin
              r_y     <= '0;
              r_valid <= 1'b1;
            end else if (w_is_bus) begin
              r_state <= S_BUSWAIT;
            end else begin
              r_y     <= w_sel_data;
              r_valid <= 1'b1;
            end
          end
        end
        S_BUSWAIT: begin
          // ack beats an expiry landing on the same edge
          if (bus_ack) begin
            r_y     <= w_bus_data;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_expire) begin
            r_y     <= '1;
            r_valid <= 1'b1;
            r_terr  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req     = (r_state == S_BUSWAIT);
  assign busy        = (r_state == S_BUSWAIT);
  assign y_out       = r_y;
  assign y_valid     = r_valid;
  assign timeout_err = r_terr;

endmodule
